icache: RTL

Direct-mapped, read-only instruction cache between the fetch stage and the shared instruction/data memory bus. On a hit it returns a 64-bit line combinationally in the same cycle the fetch address is presented. On a miss it issues one tagged BUS_LOAD, waits for the matching tagged response, and writes the line into the array; the line hits on the following cycle. At most one miss is outstanding at any time.

---
 rtl/icache.sv | 98 +++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: combinational hit path and a
// single outstanding tagged BUS_LOAD per miss.
module icache #(
  parameter int NUM_LINES = 32,
  parameter int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] proc2Icache_addr,
  input  logic        mem_stall,
  input  logic [3:0]  Imem2proc_response,
  input  logic [63:0] Imem2proc_data,
  input  logic [3:0]  Imem2proc_tag,
  output logic [63:0] Icache2proc_data,
  output logic        Icache2proc_data_valid,
  output logic [1:0]  proc2Imem_command,
  output logic [31:0] proc2Imem_addr
);
  localparam int TAG_W = 29 - IDX_W;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [NUM_LINES-1:0]           valid_q, valid_d;
  logic [NUM_LINES-1:0][TAG_W-1:0] tags_q;
  logic [NUM_LINES-1:0][63:0]     data_q;

  logic [0:0]       state_q, state_d;
  logic [3:0]       pend_tag_q, pend_tag_d;
  logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
  logic [TAG_W-1:0] pend_ltag_q, pend_ltag_d;

  logic [IDX_W-1:0] addr_idx;
  logic [TAG_W-1:0] addr_tag;
  logic             hit, miss_req, accept, fill;
  logic             unused_bits;

  assign addr_idx    = proc2Icache_addr[IDX_W+2:3];
  assign addr_tag    = proc2Icache_addr[31:IDX_W+3];
  assign unused_bits = ^proc2Icache_addr[2:0];

  assign hit      = valid_q[addr_idx] && (tags_q[addr_idx] == addr_tag);
  // Request only from IDLE on a miss while the bus is ours.
  assign miss_req = !reset && (state_q == S_IDLE) && !hit && !mem_stall;
  assign accept   = miss_req && (Imem2proc_response != 4'd0);
  assign fill     = !reset && (state_q == S_WAIT) && (Imem2proc_tag == pend_tag_q);

  assign Icache2proc_data       = data_q[addr_idx];
  assign Icache2proc_data_valid = hit && !reset;
  assign proc2Imem_command      = miss_req ? BUS_LOAD : BUS_NONE;
  assign proc2Imem_addr         = miss_req ? {proc2Icache_addr[31:3], 3'b000} : 32'd0;

  always_comb begin
    state_d     = state_q;
    pend_tag_d  = pend_tag_q;
    pend_idx_d  = pend_idx_q;
    pend_ltag_d = pend_ltag_q;
    valid_d     = valid_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d     = S_WAIT;
        pend_tag_d  = Imem2proc_response;
        pend_idx_d  = addr_idx;
        pend_ltag_d = addr_tag;
      end
      S_WAIT: if (fill) begin
        state_d             = S_IDLE;
        valid_d[pend_idx_q] = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pend_tag_q  <= 4'd0;
      pend_idx_q  <= '0;
      pend_ltag_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      pend_tag_q  <= pend_tag_d;
      pend_idx_q  <= pend_idx_d;
      pend_ltag_q <= pend_ltag_d;
      valid_q     <= valid_d;
    end
  end

  // Tag/data storage is never reset; the valid bits guard it.
  always_ff @(posedge clock) begin
    if (fill) begin
      data_q[pend_idx_q] <= Imem2proc_data;
      tags_q[pend_idx_q] <= pend_ltag_q;
    end
  end
endmodule
